pad_wake_receiver: RTL and testbench

- Input-direction counterpart to the pad output path.
- Samples the 4 pad inputs and synchronises and debounces them. Delivers clean, isolation-clamped data to the core.
- While the PMU is in SLEEP or DEEP_SLEEP, detects masked pad edges and raises wakeup_req to the PMU with a hold-until-ACTIVE handshake.
- Sits between the pad ring and the power_management_unit, on the CMU-generated clock and reset.

---
 rtl/pad_wake_receiver_pkg.sv | 24 ++
 rtl/pad_wake_receiver_channel.sv | 64 ++++++
 rtl/pad_wake_receiver.sv | 86 ++++++++
 tb/tb_pad_wake_receiver.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pad_wake_receiver_pkg.sv
// Shared definitions for the pad input receiver and the PMU.
// Power-state codes, receiver FSM states, debounce counter width.
package pad_wake_receiver_pkg;

  typedef enum logic [1:0] {
    PS_ACTIVE     = 2'b00,
    PS_SLEEP      = 2'b01,
    PS_DEEP_SLEEP = 2'b10,
    PS_WAKING     = 2'b11
  } ps_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    REQ   = 2'b10
  } rx_state_t;

  localparam int DB_W = 8;

  function automatic logic is_sleep(input logic [1:0] ps);
    return (ps == PS_SLEEP) || (ps == PS_DEEP_SLEEP);
  endfunction

endpackage

// File: rtl/pad_wake_receiver_channel.sv
// One pad: synchroniser, optional debounce (PAD_RX_DEBOUNCE_EN),
// and polarity-qualified edge detect on the debounced level.
module pad_rx_channel
  import pad_wake_receiver_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad,
  input  logic pol,
  output logic d,
  output logic e
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   d_q;

  // shift the raw pad level through the synchroniser chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], pad};
  end

  assign s = sync[SYNC_STAGES-1];

`ifdef PAD_RX_DEBOUNCE_EN
  localparam logic [DB_W-1:0] DB_LAST =
    DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] cnt;
  logic            d_r;

  // accept a new level only after it has held long enough
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      d_r <= 1'b0;
    end else if (s == d_r) begin
      cnt <= '0;
    end else if (cnt >= DB_LAST) begin
      cnt <= '0;
      d_r <= s;
    end else if (cnt != {DB_W{1'b1}}) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign d = d_r;
`else
  assign d = s;
`endif

  // one-cycle history of the level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign e = (d != d_q) && (d == pol);

endmodule

// File: rtl/pad_wake_receiver.sv
// Pad input receiver: clean core data and sleep-time wake requests.
// Build option: PAD_RX_DEBOUNCE_EN enables per-pad debounce.
module pad_wake_receiver
  import pad_wake_receiver_pkg::*;
#(
  parameter int N_PADS          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_PADS-1:0] pad_in,
  input  logic [1:0]        power_state,
  input  logic              IE,
  input  logic              ISO_EN,
  input  logic [N_PADS-1:0] wake_mask,
  input  logic [N_PADS-1:0] wake_pol,
  input  logic              wake_src_clr,
  output logic [N_PADS-1:0] Y,
  output logic              wakeup_req,
  output logic [N_PADS-1:0] wake_src
);

  logic [N_PADS-1:0] d;
  logic [N_PADS-1:0] e;
  logic [N_PADS-1:0] hit;
  logic              watch;
  rx_state_t         st;
  rx_state_t         nxt;

  for (genvar i = 0; i < N_PADS; i++) begin : g_ch
    pad_rx_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .pad  (pad_in[i]),
      .pol  (wake_pol[i]),
      .d    (d[i]),
      .e    (e[i])
    );
  end

  assign hit   = e & wake_mask;
  assign watch = (st == ARMED) || (st == REQ);

  // core data, gated by input enable and isolation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) Y <= '0;
    else        Y <= d & {N_PADS{IE & ~ISO_EN}};
  end

  // receiver state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= nxt;
  end

  // next state: arm in sleep, request on a masked edge
  always_comb begin
    nxt = st;
    unique case (st)
      IDLE:    if (is_sleep(power_state)) nxt = ARMED;
      ARMED:   if (|hit) nxt = REQ;
               else if (power_state == PS_ACTIVE) nxt = IDLE;
      REQ:     if (power_state == PS_ACTIVE) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // request decoded from the registered state
  always_comb begin
    wakeup_req = (st == REQ);
  end

  // sticky wake source: clear first, new hits win
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wake_src <= '0;
    else
      wake_src <= (wake_src_clr ? '0 : wake_src)
                | (watch ? hit : '0);
  end

endmodule

// File: tb/tb_pad_wake_receiver.sv
// Directed bench for pad_wake_receiver.
// Follows PAD_RX_DEBOUNCE_EN for latency and glitch checks.
module tb_pad_wake_receiver;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
`ifdef PAD_RX_DEBOUNCE_EN
  localparam int LAT = SYNC + DEB;
`else
  localparam int LAT = SYNC;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] pad_in;
  logic [1:0] power_state;
  logic       IE;
  logic       ISO_EN;
  logic [3:0] wake_mask;
  logic [3:0] wake_pol;
  logic       wake_src_clr;
  logic [3:0] Y;
  logic       wakeup_req;
  logic [3:0] wake_src;

  int n_cmp = 0;
  int n_err = 0;

  pad_wake_receiver #(
    .N_PADS         (4),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pad_in      (pad_in),
    .power_state (power_state),
    .IE          (IE),
    .ISO_EN      (ISO_EN),
    .wake_mask   (wake_mask),
    .wake_pol    (wake_pol),
    .wake_src_clr(wake_src_clr),
    .Y           (Y),
    .wakeup_req  (wakeup_req),
    .wake_src    (wake_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    pad_in       = 4'b0000;
    power_state  = 2'b00;
    IE           = 1'b1;
    ISO_EN       = 1'b0;
    wake_mask    = 4'b0000;
    wake_pol     = 4'b0000;
    wake_src_clr = 1'b0;
    tick(3);
    chk("rst_y", Y, 4'b0000);
    chk("rst_req", wakeup_req, 1'b0);
    chk("rst_src", wake_src, 4'b0000);
    rst_n = 1'b1;
    tick(2);

    // data path latency and isolation clamp
    pad_in = 4'b0101;
    tick(LAT);
    chk("y_pre", Y, 4'b0000);
    tick();
    chk("y_post", Y, 4'b0101);
    ISO_EN = 1'b1;
    tick();
    chk("y_iso", Y, 4'b0000);
    ISO_EN = 1'b0;
    tick();
    chk("y_uniso", Y, 4'b0101);
    IE = 1'b0;
    tick();
    chk("y_ie0", Y, 4'b0000);
    IE = 1'b1;
    tick();

`ifdef PAD_RX_DEBOUNCE_EN
    // 3-cycle glitch rejected, 4-cycle level accepted
    pad_in = 4'b0111;
    tick(3);
    pad_in = 4'b0101;
    tick(10);
    chk("glitch_y", Y, 4'b0101);
    chk("glitch_req", wakeup_req, 1'b0);
    pad_in = 4'b0111;
    tick(LAT);
    chk("hold_pre", Y, 4'b0101);
    tick();
    chk("hold_post", Y, 4'b0111);
`endif

    pad_in = 4'b0000;
    tick(LAT + 3);
    chk("y_clear", Y, 4'b0000);

    // rising wake on pad 0 from SLEEP
    power_state = 2'b01;
    wake_mask   = 4'b0001;
    wake_pol    = 4'b0001;
    tick(2);
    pad_in = 4'b0001;
    tick(LAT);
    chk("wk_pre", wakeup_req, 1'b0);
    tick();
    chk("wk_req", wakeup_req, 1'b1);
    chk("wk_src", wake_src, 4'b0001);
    power_state = 2'b11;
    tick(3);
    chk("wk_waking", wakeup_req, 1'b1);
    power_state = 2'b00;
    tick();
    chk("wk_active", wakeup_req, 1'b0);
    chk("wk_sticky", wake_src, 4'b0001);
    wake_src_clr = 1'b1;
    tick();
    wake_src_clr = 1'b0;
    chk("wk_clr", wake_src, 4'b0000);

    // falling-edge polarity, masked-off pad ignored
    pad_in = 4'b0000;
    tick(LAT + 3);
    power_state = 2'b10;
    wake_mask   = 4'b0010;
    wake_pol    = 4'b0000;
    tick(2);
    pad_in = 4'b0010;
    tick(LAT + 3);
    pad_in = 4'b1010;
    tick(LAT + 3);
    pad_in = 4'b0010;
    tick(LAT + 3);
    chk("pm_noreq", wakeup_req, 1'b0);
    chk("pm_nosrc", wake_src, 4'b0000);
    pad_in = 4'b0000;
    tick(LAT);
    chk("pm_pre", wakeup_req, 1'b0);
    tick();
    chk("pm_req", wakeup_req, 1'b1);
    chk("pm_src", wake_src, 4'b0010);
    power_state = 2'b00;
    tick();
    chk("pm_active", wakeup_req, 1'b0);

    // two pads rise together while clear pulses
    wake_mask   = 4'b1111;
    wake_pol    = 4'b1111;
    power_state = 2'b01;
    tick(2);
    chk("sim_old", wake_src, 4'b0010);
    pad_in = 4'b1100;
    tick(LAT);
    wake_src_clr = 1'b1;
    tick();
    wake_src_clr = 1'b0;
    chk("sim_src", wake_src, 4'b1100);
    chk("sim_req", wakeup_req, 1'b1);

    // async reset in the middle of a request
    rst_n = 1'b0;
    #1;
    chk("ar_req", wakeup_req, 1'b0);
    chk("ar_src", wake_src, 4'b0000);
    chk("ar_y", Y, 4'b0000);
    power_state = 2'b00;
    tick(2);
    rst_n = 1'b1;
    tick(LAT + 3);
    chk("ar_idle", wakeup_req, 1'b0);
    chk("ar_src2", wake_src, 4'b0000);
    chk("ar_y2", Y, 4'b1100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
